// File: rtl/alu_seq.sv
// alu_seq: multi-cycle Z80-style ALU producing the full S/Z/H/PV/N/C flag byte.
// Shifts and rotates iterate one bit per cycle; all other ops finish after one RUN cycle.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [4:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [7:0]       flags_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [7:0]       flags
);

    localparam int CW  = $clog2(WIDTH);
    localparam int LOW = WIDTH - 4;

    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_ADC = 5'd1;
    localparam logic [4:0] OP_SUB = 5'd2;
    localparam logic [4:0] OP_SBC = 5'd3;
    localparam logic [4:0] OP_AND = 5'd4;
    localparam logic [4:0] OP_OR  = 5'd5;
    localparam logic [4:0] OP_XOR = 5'd6;
    localparam logic [4:0] OP_CP  = 5'd7;
    localparam logic [4:0] OP_INC = 5'd8;
    localparam logic [4:0] OP_DEC = 5'd9;
    localparam logic [4:0] OP_RLC = 5'd10;
    localparam logic [4:0] OP_RRC = 5'd11;
    localparam logic [4:0] OP_RL  = 5'd12;
    localparam logic [4:0] OP_RR  = 5'd13;
    localparam logic [4:0] OP_SLA = 5'd14;
    localparam logic [4:0] OP_SRA = 5'd15;
    localparam logic [4:0] OP_SRL = 5'd16;

    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE, RUN} state_t;

    state_t           stateQ;
    logic [WIDTH-1:0] workQ;
    logic [WIDTH-1:0] bQ;
    logic [4:0]       opQ;
    logic [7:0]       fInQ;
    logic             carryQ;
    logic [CW-1:0]    cntQ;
    logic             doneQ;
    logic [WIDTH-1:0] resultQ;
    logic [7:0]       flagsQ;

    logic [WIDTH-1:0] shiftWorkD;
    logic             shiftCarryD;
    logic             isSub;
    logic             isIncDec;
    logic [WIDTH-1:0] opB;
    logic [WIDTH:0]   cinW;
    logic [WIDTH:0]   arith;
    logic             ovf;
    logic             halfC;
    logic [WIDTH-1:0] resultD;
    logic [WIDTH-1:0] flagVal;
    logic             hD;
    logic             pvD;
    logic             nD;
    logic             cD;
    logic [7:0]       flagsD;

    function automatic logic isShift(input logic [4:0] op);
        return (op >= OP_RLC) && (op <= OP_SRL);
    endfunction

    // One bit of shift/rotate; carryQ starts as flags_in[0] so a zero count leaves C untouched.
    always_comb begin
        shiftWorkD  = workQ;
        shiftCarryD = carryQ;
        case (opQ)
            OP_RLC: begin
                shiftCarryD = workQ[WIDTH-1];
                shiftWorkD  = {workQ[WIDTH-2:0], workQ[WIDTH-1]};
            end
            OP_RRC: begin
                shiftCarryD = workQ[0];
                shiftWorkD  = {workQ[0], workQ[WIDTH-1:1]};
            end
            OP_RL: begin
                shiftCarryD = workQ[WIDTH-1];
                shiftWorkD  = {workQ[WIDTH-2:0], carryQ};
            end
            OP_RR: begin
                shiftCarryD = workQ[0];
                shiftWorkD  = {carryQ, workQ[WIDTH-1:1]};
            end
            OP_SLA: begin
                shiftCarryD = workQ[WIDTH-1];
                shiftWorkD  = {workQ[WIDTH-2:0], 1'b0};
            end
            OP_SRA: begin
                shiftCarryD = workQ[0];
                shiftWorkD  = {workQ[WIDTH-1], workQ[WIDTH-1:1]};
            end
            OP_SRL: begin
                shiftCarryD = workQ[0];
                shiftWorkD  = {1'b0, workQ[WIDTH-1:1]};
            end
            default: ;
        endcase
    end

    // Half carry/borrow is recovered as the carry into bit LOW: a ^ b ^ sum at that bit.
    always_comb begin
        isSub    = (opQ == OP_SUB) || (opQ == OP_SBC) || (opQ == OP_CP) || (opQ == OP_DEC);
        isIncDec = (opQ == OP_INC) || (opQ == OP_DEC);
        opB      = isIncDec ? ONE : bQ;
        cinW     = {{WIDTH{1'b0}}, ((opQ == OP_ADC) || (opQ == OP_SBC)) & fInQ[0]};
        if (isSub) begin
            arith = {1'b0, workQ} - {1'b0, opB} - cinW;
            ovf   = (workQ[WIDTH-1] != opB[WIDTH-1]) && (arith[WIDTH-1] != workQ[WIDTH-1]);
        end else begin
            arith = {1'b0, workQ} + {1'b0, opB} + cinW;
            ovf   = (workQ[WIDTH-1] == opB[WIDTH-1]) && (arith[WIDTH-1] != workQ[WIDTH-1]);
        end
        halfC = workQ[LOW] ^ opB[LOW] ^ arith[LOW];
    end

    always_comb begin
        resultD = workQ;
        flagVal = workQ;
        hD      = 1'b0;
        pvD     = 1'b0;
        nD      = 1'b0;
        cD      = 1'b0;
        case (opQ)
            OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CP, OP_INC, OP_DEC: begin
                resultD = (opQ == OP_CP) ? workQ : arith[WIDTH-1:0];
                flagVal = arith[WIDTH-1:0];
                hD      = halfC;
                pvD     = ovf;
                nD      = isSub;
                cD      = isIncDec ? fInQ[0] : arith[WIDTH];
            end
            OP_AND, OP_OR, OP_XOR: begin
                if (opQ == OP_AND) begin
                    resultD = workQ & bQ;
                end else if (opQ == OP_OR) begin
                    resultD = workQ | bQ;
                end else begin
                    resultD = workQ ^ bQ;
                end
                flagVal = resultD;
                hD      = (opQ == OP_AND);
                pvD     = ~^resultD;
            end
            OP_RLC, OP_RRC, OP_RL, OP_RR, OP_SLA, OP_SRA, OP_SRL: begin
                pvD = ~^workQ;
                cD  = carryQ;
            end
            default: ;
        endcase
        if (opQ > OP_SRL) begin
            flagsD = fInQ;
        end else begin
            flagsD = {flagVal[WIDTH-1], (flagVal == '0), 1'b0, hD, 1'b0, pvD, nD, cD};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ  <= IDLE;
            workQ   <= '0;
            bQ      <= '0;
            opQ     <= '0;
            fInQ    <= '0;
            carryQ  <= 1'b0;
            cntQ    <= '0;
            doneQ   <= 1'b0;
            resultQ <= '0;
            flagsQ  <= '0;
        end else begin
            doneQ <= 1'b0;
            case (stateQ)
                IDLE: begin
                    if (start) begin
                        workQ  <= a;
                        bQ     <= b;
                        opQ    <= opcode;
                        fInQ   <= flags_in;
                        carryQ <= flags_in[0];
                        cntQ   <= isShift(opcode) ? b[CW-1:0] : '0;
                        stateQ <= RUN;
                    end
                end
                RUN: begin
                    if (cntQ != '0) begin
                        workQ  <= shiftWorkD;
                        carryQ <= shiftCarryD;
                        cntQ   <= cntQ - CNT_ONE;
                    end else begin
                        resultQ <= resultD;
                        flagsQ  <= flagsD;
                        doneQ   <= 1'b1;
                        stateQ  <= IDLE;
                    end
                end
                default: stateQ <= IDLE;
            endcase
        end
    end

    assign busy   = (stateQ == RUN);
    assign done   = doneQ;
    assign result = resultQ;
    assign flags  = flagsQ;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: 8- and 16-bit instances checked every cycle against an arithmetic
// reference model, plus directed vectors with hand-computed results and flags.
module tb_alu_seq;

    logic        clk;
    logic        rst_n;
    logic        start8, start16;
    logic [4:0]  op8, op16;
    logic [7:0]  a8, b8, fin8;
    logic [15:0] a16, b16;
    logic [7:0]  fin16;
    logic        busy8, done8, busy16, done16;
    logic [7:0]  res8, fl8, fl16;
    logic [15:0] res16;

    int nCompared = 0;
    int nFailed   = 0;
    int cycle     = 0;

    typedef struct {
        bit busy;
        bit done;
        int due;
        int res;
        int fl;
        int pRes;
        int pFl;
    } model_t;

    model_t m8, m16;

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .opcode(op8), .a(a8), .b(b8),
        .flags_in(fin8), .busy(busy8), .done(done8), .result(res8), .flags(fl8)
    );

    alu_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .opcode(op16), .a(a16), .b(b16),
        .flags_in(fin16), .busy(busy16), .done(done16), .result(res16), .flags(fl16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkEq(input string name, input int actual, input int expected);
        nCompared++;
        if (actual != expected) begin
            nFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic int evenParity(input longint x);
        int ones = 0;
        for (int i = 0; i < 32; i++) ones += int'((x >> i) & 1);
        return (ones % 2 == 0) ? 1 : 0;
    endfunction

    function automatic longint sgn(input longint x, input longint mod);
        return (x >= (mod >> 1)) ? x - mod : x;
    endfunction

    // Reference: what result/flags an op must produce, and how many shift cycles it takes.
    function automatic void computeOp(input int w, input int op, input longint a, input longint b,
                                      input int fin, output longint res, output int fl, output int n);
        longint mod, half, hmod, bb, full, sr, x, y, y2;
        int ci, cadd, c, h, v, nn, k, s, z;
        mod  = longint'(1) << w;
        half = mod >> 1;
        hmod = longint'(1) << (w - 4);
        ci   = fin & 1;
        n = 0; c = 0; h = 0; v = 0; nn = 0; x = a; res = a;
        if (op >= 17) begin
            fl = fin;
            return;
        end
        case (op)
            0, 1, 8: begin
                bb   = (op == 8) ? 1 : b;
                cadd = (op == 1) ? ci : 0;
                full = a + bb + cadd;
                x    = full & (mod - 1);
                c    = (full >= mod) ? 1 : 0;
                h    = (((a % hmod) + (bb % hmod) + cadd) >= hmod) ? 1 : 0;
                sr   = sgn(a, mod) + sgn(bb, mod) + cadd;
                v    = (sr >= half || sr < -half) ? 1 : 0;
                if (op == 8) c = ci;
                res  = x;
            end
            2, 3, 7, 9: begin
                bb   = (op == 9) ? 1 : b;
                cadd = (op == 3) ? ci : 0;
                full = a - bb - cadd;
                x    = full & (mod - 1);
                c    = (full < 0) ? 1 : 0;
                h    = (((a % hmod) - (bb % hmod) - cadd) < 0) ? 1 : 0;
                sr   = sgn(a, mod) - sgn(bb, mod) - cadd;
                v    = (sr >= half || sr < -half) ? 1 : 0;
                nn   = 1;
                if (op == 9) c = ci;
                res  = (op == 7) ? a : x;
            end
            4, 5, 6: begin
                x   = (op == 4) ? (a & b) : (op == 5) ? (a | b) : (a ^ b);
                h   = (op == 4) ? 1 : 0;
                v   = evenParity(x);
                res = x;
            end
            default: begin
                k = int'(b % w);
                n = k;
                if (k == 0) begin
                    x = a;
                    c = ci;
                end else begin
                    y = (longint'(ci) << w) | a;
                    case (op)
                        10: begin x = ((a << k) | (a >> (w - k))) & (mod - 1); c = int'(x & 1); end
                        11: begin x = ((a >> k) | (a << (w - k))) & (mod - 1); c = int'((x >> (w - 1)) & 1); end
                        12: begin
                            y2 = ((y << k) | (y >> (w + 1 - k))) & (2 * mod - 1);
                            x  = y2 & (mod - 1);
                            c  = int'(y2 >> w);
                        end
                        13: begin
                            y2 = ((y >> k) | (y << (w + 1 - k))) & (2 * mod - 1);
                            x  = y2 & (mod - 1);
                            c  = int'(y2 >> w);
                        end
                        14: begin x = (a << k) & (mod - 1); c = int'((a >> (w - k)) & 1); end
                        15: begin x = (sgn(a, mod) >>> k) & (mod - 1); c = int'((a >> (k - 1)) & 1); end
                        default: begin x = a >> k; c = int'((a >> (k - 1)) & 1); end
                    endcase
                end
                v   = evenParity(x);
                res = x;
            end
        endcase
        s  = (x >= half) ? 1 : 0;
        z  = (x == 0) ? 1 : 0;
        fl = s * 128 + z * 64 + h * 16 + v * 4 + nn * 2 + c;
    endfunction

    function automatic model_t modelStep(input model_t m, input int w, input logic rstn, input logic st,
                                         input int op, input int a, input int b, input int fin, input int cyc);
        model_t nx = m;
        longint r;
        int f, n;
        if (!rstn) begin
            nx.busy = 0; nx.done = 0; nx.res = 0; nx.fl = 0; nx.due = 0;
            return nx;
        end
        nx.done = 0;
        if (m.busy) begin
            if (cyc == m.due) begin
                nx.busy = 0; nx.done = 1; nx.res = m.pRes; nx.fl = m.pFl;
            end
        end else if (st) begin
            computeOp(w, op, longint'(a), longint'(b), fin, r, f, n);
            nx.pRes = int'(r);
            nx.pFl  = f;
            nx.due  = cyc + 1 + n;
            nx.busy = 1;
        end
        return nx;
    endfunction

    always @(posedge clk) begin
        cycle <= cycle + 1;
        m8  <= modelStep(m8, 8, rst_n, start8, int'(op8), int'(a8), int'(b8), int'(fin8), cycle);
        m16 <= modelStep(m16, 16, rst_n, start16, int'(op16), int'(a16), int'(b16), int'(fin16), cycle);
    end

    always @(posedge clk) begin
        #1;
        checkEq("cmp8.busy", int'(busy8), int'(m8.busy));
        checkEq("cmp8.done", int'(done8), int'(m8.done));
        checkEq("cmp8.result", int'(res8), m8.res);
        checkEq("cmp8.flags", int'(fl8), m8.fl);
        checkEq("cmp16.busy", int'(busy16), int'(m16.busy));
        checkEq("cmp16.done", int'(done16), int'(m16.done));
        checkEq("cmp16.result", int'(res16), m16.res);
        checkEq("cmp16.flags", int'(fl16), m16.fl);
    end

    // Drives one start pulse from the current negedge; returns at the negedge after the accepting edge.
    task automatic applyStimulus(input bit wide, input int op, input int a, input int b, input int fin);
        if (wide) begin
            start16 = 1'b1; op16 = 5'(op); a16 = 16'(a); b16 = 16'(b); fin16 = 8'(fin);
        end else begin
            start8 = 1'b1; op8 = 5'(op); a8 = 8'(a); b8 = 8'(b); fin8 = 8'(fin);
        end
        @(negedge clk);
        start8  = 1'b0;
        start16 = 1'b0;
    endtask

    task automatic waitDone(input bit wide, output int waited);
        waited = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if ((wide ? done16 : done8) == 1'b1) begin
                waited = i;
                return;
            end
        end
    endtask

    task automatic checkOutput(input string name, input bit wide, input int expRes, input int expFl);
        checkEq({name, ".done"}, wide ? int'(done16) : int'(done8), 1);
        checkEq({name, ".result"}, wide ? int'(res16) : int'(res8), expRes);
        checkEq({name, ".flags"}, wide ? int'(fl16) : int'(fl8), expFl);
    endtask

    task automatic runOp(input string name, input bit wide, input int op, input int a, input int b,
                         input int fin, input int expRes, input int expFl, input int expLat);
        int waited;
        applyStimulus(wide, op, a, b, fin);
        waitDone(wide, waited);
        checkEq({name, ".latency"}, waited, expLat);
        checkOutput(name, wide, expRes, expFl);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int waited;
        int busyCycles;
        int gotDone;
        int sawDone;
        rst_n = 1'b0;
        start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0; fin8 = '0;
        start16 = 1'b0; op16 = '0; a16 = '0; b16 = '0; fin16 = '0;
        repeat (2) @(negedge clk);
        checkEq("reset.busy8", int'(busy8), 0);
        checkEq("reset.done8", int'(done8), 0);
        checkEq("reset.result8", int'(res8), 0);
        checkEq("reset.flags8", int'(fl8), 0);
        checkEq("reset.busy16", int'(busy16), 0);
        checkEq("reset.result16", int'(res16), 0);
        checkEq("reset.flags16", int'(fl16), 0);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(0, 0, 'h7F, 'h01, 'h00);
        checkEq("add.busy_after_accept", int'(busy8), 1);
        checkEq("add.done_not_yet", int'(done8), 0);
        waitDone(0, waited);
        checkEq("add.latency", waited, 1);
        checkOutput("add", 0, 'h80, 'h94);

        runOp("sbc", 0, 3, 'h00, 'h00, 'h01, 'hFF, 'h93, 1);

        applyStimulus(0, 12, 'h81, 3, 'h00);
        busyCycles = int'(busy8);
        gotDone = 0;
        for (int i = 0; i < 20 && gotDone == 0; i++) begin
            @(negedge clk);
            if (i == 0) begin
                start8 = 1'b1; op8 = 5'd4; a8 = 8'hF0; b8 = 8'h0F;
            end
            if (i == 1) start8 = 1'b0;
            if (done8) gotDone = 1;
            else busyCycles += int'(busy8);
        end
        checkEq("rl.done_seen", gotDone, 1);
        checkEq("rl.busy_cycles", busyCycles, 4);
        checkOutput("rl", 0, 'h0A, 'h04);

        applyStimulus(0, 4, 'hF0, 'h0F, 'h00);
        checkEq("and.accepted_in_done_cycle", int'(busy8), 1);
        waitDone(0, waited);
        checkEq("and.latency", waited, 1);
        checkOutput("and", 0, 'h00, 'h54);

        runOp("add16", 1, 0, 'hFFFF, 'h0001, 'h00, 'h0000, 'h51, 1);
        runOp("inc16", 1, 8, 'h7FFF, 'h0000, 'h01, 'h8000, 'h95, 1);
        runOp("sub16", 1, 2, 'h8000, 'h0001, 'h00, 'h7FFF, 'h16, 1);
        runOp("srl16", 1, 16, 'h8000, 15, 'h00, 'h0001, 'h00, 16);
        runOp("rlc16_mod", 1, 10, 'h8001, 17, 'h00, 'h0003, 'h05, 2);

        runOp("sub", 0, 2, 'h10, 'h01, 'h00, 'h0F, 'h12, 1);
        runOp("cp", 0, 7, 'h05, 'h05, 'h00, 'h05, 'h42, 1);
        runOp("xor", 0, 6, 'hFF, 'h0F, 'h00, 'hF0, 'h84, 1);
        runOp("or", 0, 5, 'h01, 'h02, 'h00, 'h03, 'h04, 1);
        runOp("dec", 0, 9, 'h80, 'h00, 'h01, 'h7F, 'h17, 1);
        runOp("adc", 0, 1, 'hFF, 'h00, 'h01, 'h00, 'h51, 1);
        runOp("rlc", 0, 10, 'h81, 1, 'h00, 'h03, 'h05, 2);
        runOp("rrc_mod", 0, 11, 'h01, 9, 'h00, 'h80, 'h81, 2);
        runOp("sla", 0, 14, 'hC0, 2, 'h00, 'h00, 'h45, 3);
        runOp("sra", 0, 15, 'h81, 2, 'h00, 'hE0, 'h80, 3);
        runOp("srl", 0, 16, 'h81, 1, 'h00, 'h40, 'h01, 2);
        runOp("rr", 0, 13, 'h01, 1, 'h00, 'h00, 'h45, 2);
        runOp("rlc_cnt0", 0, 10, 'h03, 8, 'h01, 'h03, 'h05, 1);
        runOp("illegal", 0, 20, 'h5A, 'h00, 'hA5, 'h5A, 'hA5, 1);

        applyStimulus(0, 13, 'h55, 7, 'h00);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkEq("rr_reset.busy8", int'(busy8), 0);
        checkEq("rr_reset.done8", int'(done8), 0);
        checkEq("rr_reset.result8", int'(res8), 0);
        checkEq("rr_reset.flags8", int'(fl8), 0);
        checkEq("rr_reset.result16", int'(res16), 0);
        checkEq("rr_reset.flags16", int'(fl16), 0);
        @(negedge clk);
        rst_n = 1'b1;
        sawDone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) sawDone = 1;
        end
        checkEq("rr_reset.no_done_after_release", sawDone, 0);
        checkEq("rr_reset.idle_after_release", int'(busy8), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised multi-cycle successor to the combinational 8-bit Z80 ALU. It registers operands on a start/done handshake and produces the full Z80 flag byte (S, Z, H, P/V, N, C). It supports carry-in arithmetic (ADC/SBC) and performs multi-bit shifts and rotates iteratively, one bit per cycle. It sits between the decode/control FSM and the register file; the control FSM supplies the current F register as `flags_in`.

## Interface
- `WIDTH`, default 8: datapath width; legal values are 8 and 16.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: request; sampled only while `busy`=0.
- `opcode` in 5: operation select, encoding below.
- `a` in WIDTH: operand A / shift source.
- `b` in WIDTH: operand B; for shifts and rotates, the count is `b mod WIDTH`.
- `flags_in` in 8: current F register; bit 0 supplies carry-in.
- `busy` out 1: high while an operation is in flight.
- `done` out 1: single-cycle pulse; `result` and `flags` are valid from this cycle.
- `result` out WIDTH: registered result, held until the next `done`.
- `flags` out 8: registered flag byte laid out as 7 S, 6 Z, 5 0, 4 H, 3 0, 2 P/V, 1 N, 0 C.

## Operation
- Opcode encoding: 0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 AND, 5 OR, 6 XOR, 7 CP, 8 INC, 9 DEC, 10 RLC, 11 RRC, 12 RL, 13 RR, 14 SLA, 15 SRA, 16 SRL. Codes 17–31 are illegal.
- FSM has two states, IDLE and RUN; `busy` = (state==RUN).
- IDLE, `start`=1: latch `a`, `b`, `opcode`, `flags_in`; load `cnt` = 0 for non-shift ops, or `b mod WIDTH` for ops 10–16; go to RUN.
- RUN, `cnt`≠0: shift the working register one bit; C takes the bit shifted out; `cnt` decrements.
- RUN, `cnt`=0: write `result` and `flags`; pulse `done`; return to IDLE.
- Arithmetic is computed at WIDTH+1 bits.
  - C = carry/borrow out of the MSB.
  - H = carry/borrow out of bit WIDTH-5 (bit 3 for 8-bit, bit 11 for 16-bit).
  - P/V = signed overflow.
  - ADC/SBC add or subtract `flags_in[0]`.
  - N=1 for SUB, SBC, CP, DEC; N=0 otherwise.
- CP: flags computed as SUB; `result` = `a` unchanged.
- INC/DEC: compute a±1; C = `flags_in[0]` (preserved); H and P/V as for ADD/SUB with B=1.
- AND: H=1. OR/XOR: H=0. All three: C=0, N=0, P/V = even parity of result (1 = even).
- Shift/rotate ops (N=0, H=0, P/V = parity) behave as follows:
  - RLC/RRC: circular.
  - RL/RR: through carry, with C initialised from `flags_in[0]`.
  - SLA: shift left, LSB=0.
  - SRA: shift right, MSB kept.
  - SRL: shift right, MSB=0.
- Shift/rotate count 0: `result` = `a`, C = `flags_in[0]`; other flags are computed from `a`.
- S = result MSB and Z = (result==0) for every op, including CP (computed from the difference).
- Illegal opcode: `result` = `a`, `flags` = `flags_in`; completes with the one-cycle latency.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0, `flags`=0x00, `cnt`=0.
- Reset acts immediately and asynchronously, and aborts any in-flight operation with no `done`.
- `start` accepted at edge k: `busy`=1 from edge k. `done` is asserted for the single cycle following edge k+1+n, where n = 0 for non-shift ops and n = `b mod WIDTH` for shifts. `busy` deasserts at that same edge.
- `start` while `busy`=1 is ignored; it is not queued.
- `start` during the `done` cycle is legal and accepted (`busy`=0). Peak throughput is one op per 2 cycles.
- Inputs other than `start` are don't-care after the accepting edge.
- `result` and `flags` change only at the `done` edge.

## Test plan
- WIDTH=8, ADD: a=0x7F, b=0x01 -> `result`=0x80, `flags`=0x94 (S, H, V); `done` one cycle after the accepting edge.
- SBC: a=0x00, b=0x00, `flags_in`=0x01 -> `result`=0xFF, `flags`=0x93 (S, H, N, C).
- RL: a=0x81, b=3, `flags_in`=0x00 -> `busy` high 4 cycles, `result`=0x0A, `flags`=0x04. Pulse `start` with AND a=0xF0, b=0x0F mid-shift -> ignored.
- AND: a=0xF0, b=0x0F issued in the `done` cycle -> accepted; `result`=0x00, `flags`=0x54 (Z, H, P).
- Drop `rst_n` during RR with b=7 -> `busy`, `done`, `result`, `flags` all 0 immediately; no `done` follows release.
- WIDTH=16, ADD: a=0xFFFF, b=0x0001 -> `result`=0x0000, `flags`=0x51 (Z, H, C). INC a=0x7FFF, `flags_in`=0x01 -> 0x8000, `flags`=0x95 (S, H, V, C preserved).
